seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Parametrised multi-digit 7-segment display controller that replaces per-digit combinational decoders between a design's data path and the board HEX outputs. It captures a binary value on a load strobe and shows it in hexadecimal or decimal, the latter through a sequential double-dabble converter. It adds leading-zero blanking, overflow indication and per-digit blinking. It sits inside a `top`, driving the HEX0…HEXn ports presented to the simulator testbench.

## Interface
- `DIGITS`, 6: number of 7-segment digits driven (1–8).
- `W`, 20: width of `value` (W ≥ 4; must cover 10^DIGITS−1 for full decimal range).
- `BLINK_DIV`, 25000000: clock cycles per blink half-period (≥ 2).

- `CLOCK_50`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `value`  in  W  binary value to display.
- `load`  in  1  capture `value`, `mode_dec` and `blank_lz` when idle.
- `mode_dec`  in  1  1 = decimal, 0 = hexadecimal.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `blink_mask`  in  DIGITS  bit i = 1 makes digit i blink; sampled live.
- `HEX`  out  7*DIGITS  active-low segments; `HEX[7i+6:7i]` = digit i (digit 0 least significant); bit 0 = seg a … bit 6 = seg g.
- `busy`  out  1  capture/conversion in progress; loads ignored.
- `overflow`  out  1  last displayed value did not fit in DIGITS digits.

## Operation
- FSM states: IDLE, CONV, SHOW.
- IDLE: `load`=1 captures inputs. Hex mode → SHOW. Decimal mode → CONV with iteration count 0 and BCD register (4*DIGITS bits) cleared.
- CONV: one double-dabble iteration per cycle: add 3 to every BCD nibble ≥ 5, then shift left one bit, bringing in the next MSB of the captured value. After W iterations → SHOW.
- SHOW: one cycle. Updates the per-digit segment registers and `overflow`, then → IDLE.
- `load` in CONV or SHOW is ignored, not queued.
- Overflow:
  - Decimal: captured value ≥ 10^DIGITS.
  - Hex: any captured bit at or above 4*DIGITS is set (only possible when W > 4*DIGITS).
  - On overflow every digit shows a dash (7'h3F); blanking is not applied.
- Digit decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). Blank = 7'h7F.
- Leading-zero blanking (blank_lz=1, no overflow): every digit above the most significant nonzero digit is blank. Digit 0 is always shown, so a value of 0 displays a single "0".
- Blink:
  - Free-running counter 0…BLINK_DIV−1; `phase` toggles on each wrap.
  - While `phase`=1, digit i is forced to 7'h7F if `blink_mask[i]`.
  - Blink has no effect on `busy`, `overflow` or conversion.
- `HEX` is a function of flops only (segment registers, `phase`) and the live `blink_mask`; it never shows intermediate conversion values.

## Timing
- Reset (async assert, sync release on next edge):
  - `HEX` = all 1s (all digits blank).
  - `busy`=0, `overflow`=0, FSM=IDLE, blink counter=0, `phase`=0.
  - Asserting reset mid-conversion aborts the conversion and blanks the display.
- Load sampled at edge k, hex mode:
  - `busy`=1 after edge k.
  - `HEX` and `overflow` valid and `busy`=0 after edge k+1.
  - Latency 2 edges.
- Load sampled at edge k, decimal mode:
  - `busy`=1 after edge k.
  - W iterations on edges k+1…k+W.
  - `HEX`, `overflow` update and `busy`=0 after edge k+W+1.
- Earliest next load is the cycle `busy` is 0 (back-to-back loads are accepted every 2 cycles in hex mode).
- `phase` toggles every BLINK_DIV cycles from reset; full blink period is 2*BLINK_DIV.
- `blink_mask` changes take effect combinationally on `HEX`.
- The previous display is held unchanged while `busy`=1.

## Test plan
- Reset: assert `resetn`=0 mid-decimal conversion → `HEX`=42'h3FFFFFFFFFF, `busy`=0 immediately; no update after release.
- Hex: DIGITS=6, W=20, load `value`=20'hABCD, `mode_dec`=0, `blank_lz`=1 → after 2 edges digits 0..3 = d,C,b,A (21,46,03,08), digits 4–5 = 7F, `overflow`=0.
- Decimal: load 123456, `mode_dec`=1, `blank_lz`=0 → `busy` high 21 cycles, then digits 0..5 = 6,5,4,3,2,1 (02,12,19,30,24,79); 0 with `blank_lz`=1 → only digit 0 = 40.
- Overflow: decimal load 1000000 (20'hF4240) → all digits 3F, `overflow`=1; following load 999999 → 9s, `overflow`=0.
- Load during busy: second `load` of 5 at cycle k+3 of a decimal conversion of 42 → display shows 42, no further `busy` pulse.
- Blink: BLINK_DIV=4, `blink_mask`=6'b000001 after showing 7 → digit 0 alternates 78 / 7F every 4 cycles; other digits steady.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment display controller: captures a binary value on load and shows it in
// hex or decimal (sequential double-dabble), with leading-zero blanking, overflow and blink.
module seg_display_ctrl #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned W         = 20,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [W-1:0]          value,
    input  logic                  load,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned XW = (W > BW) ? W : BW;
    localparam int unsigned IW = $clog2(W + 1);
    localparam int unsigned CW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {StIdle, StConv, StShow} state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        val_q;
    logic                dec_q, blz_q;
    logic [BW-1:0]       bcd_q, bcd_adj;
    logic [IW-1:0]       iter_q;
    logic                dec_ovf_q;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       blink_cnt_q;
    logic                phase_q;

    logic [XW-1:0]       val_x;
    logic [BW-1:0]       nibs;
    logic                hex_ovf;
    logic                lead;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'h40;
            4'h1:    seg_decode = 7'h79;
            4'h2:    seg_decode = 7'h24;
            4'h3:    seg_decode = 7'h30;
            4'h4:    seg_decode = 7'h19;
            4'h5:    seg_decode = 7'h12;
            4'h6:    seg_decode = 7'h02;
            4'h7:    seg_decode = 7'h78;
            4'h8:    seg_decode = 7'h00;
            4'h9:    seg_decode = 7'h10;
            4'hA:    seg_decode = 7'h08;
            4'hB:    seg_decode = 7'h03;
            4'hC:    seg_decode = 7'h46;
            4'hD:    seg_decode = 7'h21;
            4'hE:    seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // FSM: state register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load) state_d = mode_dec ? StConv : StShow;
            StConv:  if (iter_q == IW'(W - 1)) state_d = StShow;
            StShow:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q != StIdle);
        overflow = ovf_q;
    end

    // Double-dabble adjust step applied before each shift
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
    end

    // Final digit selection, overflow and blanking evaluated in SHOW
    always_comb begin
        val_x   = XW'(val_q);
        hex_ovf = |(val_x >> BW);
        nibs    = dec_q ? bcd_q : val_x[BW-1:0];
        ovf_d   = dec_q ? dec_ovf_q : hex_ovf;
        lead    = 1'b1;
        seg_d   = '1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lead = lead & (nibs[4*i +: 4] == 4'd0);
            if (ovf_d)                         seg_d[7*i +: 7] = 7'h3F;
            else if (blz_q && lead && (i != 0)) seg_d[7*i +: 7] = 7'h7F;
            else                               seg_d[7*i +: 7] = seg_decode(nibs[4*i +: 4]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            val_q     <= '0;
            dec_q     <= 1'b0;
            blz_q     <= 1'b0;
            bcd_q     <= '0;
            iter_q    <= '0;
            dec_ovf_q <= 1'b0;
            seg_q     <= '1;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        val_q     <= value;
                        dec_q     <= mode_dec;
                        blz_q     <= blank_lz;
                        bcd_q     <= '0;
                        iter_q    <= '0;
                        dec_ovf_q <= 1'b0;
                    end
                end
                StConv: begin
                    bcd_q     <= {bcd_adj[BW-2:0], val_q[W-1]};
                    val_q     <= val_q << 1;
                    iter_q    <= iter_q + IW'(1);
                    // Any digit carried out of the top nibble means value >= 10^DIGITS
                    dec_ovf_q <= dec_ovf_q | bcd_adj[BW-1];
                end
                StShow: begin
                    seg_q <= seg_d;
                    ovf_q <= ovf_d;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CW'(1);
        end
    end

    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            HEX[7*i +: 7] = (phase_q && blink_mask[i]) ? 7'h7F : seg_q[7*i +: 7];
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed scenarios plus randomized loads checked
// against an arithmetic reference model of the displayed digits.
module tb_seg_display_ctrl;

    localparam int unsigned DIGITS    = 6;
    localparam int unsigned W         = 20;
    localparam int unsigned BLINK_DIV = 4;

    logic                CLOCK_50 = 1'b0;
    logic                resetn;
    logic [W-1:0]        value;
    logic                load, mode_dec, blank_lz;
    logic [DIGITS-1:0]   blink_mask;
    logic [7*DIGITS-1:0] HEX;
    logic                busy, overflow;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned edges;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_display_ctrl #(.DIGITS(DIGITS), .W(W), .BLINK_DIV(BLINK_DIV)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .value      (value),
        .load       (load),
        .mode_dec   (mode_dec),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .HEX        (HEX),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Edges since reset release, for the blink phase model
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) edges <= 0;
        else         edges <= edges + 1;
    end

    function automatic bit model_ovf(input int unsigned v, input bit dec);
        if (dec) return v >= 1000000;
        return (v >> (4 * DIGITS)) != 0;
    endfunction

    function automatic logic [7*DIGITS-1:0] model_hex(input int unsigned v, input bit dec,
                                                      input bit blz);
        int unsigned d [DIGITS];
        int unsigned p = 1;
        int          top = 0;
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d[i] = dec ? (v / p) % 10 : (v >> (4 * i)) & 15;
            p = p * 10;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (model_ovf(v, dec))   r[7*i +: 7] = 7'h3F;
            else if (blz && i > top) r[7*i +: 7] = 7'h7F;
            else                     r[7*i +: 7] = seg_tab[d[i]];
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] apply_blink(input logic [7*DIGITS-1:0] d,
                                                        input logic [DIGITS-1:0] m);
        logic [7*DIGITS-1:0] r = d;
        bit ph = ((edges / BLINK_DIV) % 2) == 1;
        for (int i = 0; i < int'(DIGITS); i++) if (ph && m[i]) r[7*i +: 7] = 7'h7F;
        return r;
    endfunction

    task automatic start_load(input int unsigned v, input bit dec, input bit blz);
        @(negedge CLOCK_50);
        value = W'(v); mode_dec = dec; blank_lz = blz; load = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
    endtask

    // Counts negedge samples with busy high, starting at the current one
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        int cyc;
        logic [7*DIGITS-1:0] all_blank = '1;
        resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        n_cmp++; if (HEX !== all_blank) begin n_fail++; $display("FAIL reset_hex: got %h want %h", HEX, all_blank); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        start_load(32'h12345, 1'b0, 1'b0);
        wait_idle(cyc);
        start_load(123456, 1'b1, 1'b0);
        repeat (3) @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (HEX !== all_blank) begin n_fail++; $display("FAIL midconv_reset_hex: got %h want %h", HEX, all_blank); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midconv_reset_busy: got %b want 0", busy); end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        n_cmp++; if (HEX !== all_blank || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_hold: got hex %h busy %b want %h busy 0", HEX, busy, all_blank);
        end
    endtask

    task automatic test_hex();
        logic [7*DIGITS-1:0] exp = model_hex(32'hABCD, 1'b0, 1'b1);
        start_load(32'hABCD, 1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hex_busy: got %b want 1", busy); end
        @(negedge CLOCK_50);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hex_done: got %b want 0", busy); end
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL hex_seg: got %h want %h", HEX, exp); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_decimal();
        int cyc;
        logic [7*DIGITS-1:0] exp;
        start_load(123456, 1'b1, 1'b0);
        wait_idle(cyc);
        n_cmp++; if (cyc != int'(W) + 1) begin n_fail++; $display("FAIL dec_busy_len: got %0d want %0d", cyc, W + 1); end
        exp = model_hex(123456, 1'b1, 1'b0);
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL dec_seg: got %h want %h", HEX, exp); end
        start_load(0, 1'b1, 1'b1);
        wait_idle(cyc);
        exp = model_hex(0, 1'b1, 1'b1);
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL dec_zero_blank: got %h want %h", HEX, exp); end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [7*DIGITS-1:0] exp;
        start_load(1000000, 1'b1, 1'b1);
        wait_idle(cyc);
        exp = model_hex(1000000, 1'b1, 1'b1);
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL ovf_dash: got %h want %h", HEX, exp); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        start_load(999999, 1'b1, 1'b1);
        wait_idle(cyc);
        exp = model_hex(999999, 1'b1, 1'b1);
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL ovf_nines: got %h want %h", HEX, exp); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_load_busy();
        int cyc;
        int seen = 0;
        logic [7*DIGITS-1:0] exp = model_hex(42, 1'b1, 1'b1);
        start_load(42, 1'b1, 1'b1);
        repeat (2) @(negedge CLOCK_50);
        value = W'(5); mode_dec = 1'b0; load = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
        wait_idle(cyc);
        n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL busy_load_seg: got %h want %h", HEX, exp); end
        repeat (30) begin
            @(negedge CLOCK_50);
            if (busy === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL busy_load_ignored: got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_blink();
        int cyc;
        logic [7*DIGITS-1:0] base = model_hex(7, 1'b0, 1'b0);
        start_load(7, 1'b0, 1'b0);
        wait_idle(cyc);
        blink_mask = 6'b000001;
        #1;
        n_cmp++; if (HEX !== apply_blink(base, blink_mask)) begin
            n_fail++; $display("FAIL blink_comb: got %h want %h", HEX, apply_blink(base, blink_mask));
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            n_cmp++; if (HEX !== apply_blink(base, blink_mask)) begin
                n_fail++; $display("FAIL blink_cyc%0d: got %h want %h", i, HEX, apply_blink(base, blink_mask));
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_back_to_back();
        int unsigned v [4];
        logic [7*DIGITS-1:0] exp;
        for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, (1 << W) - 1);
        @(negedge CLOCK_50);
        value = W'(v[0]); mode_dec = 1'b0; blank_lz = 1'b1; load = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLOCK_50);
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy%0d: got %b want 1", j, busy); end
            @(negedge CLOCK_50);
            exp = model_hex(v[j], 1'b0, 1'b1);
            n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL b2b_seg%0d: got %h want %h", j, HEX, exp); end
            if (j < 3) value = W'(v[j+1]);
            else       load = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            int unsigned v = $urandom_range(0, (1 << W) - 1);
            bit dec = $urandom_range(0, 1) == 1;
            bit blz = $urandom_range(0, 1) == 1;
            logic [7*DIGITS-1:0] prev = HEX;
            logic [7*DIGITS-1:0] exp = model_hex(v, dec, blz);
            int cyc = 0;
            if (t < 4) v = $urandom_range(0, 999);
            exp = model_hex(v, dec, blz);
            start_load(v, dec, blz);
            while (busy === 1'b1 && cyc < 200) begin
                n_cmp++; if (HEX !== prev) begin n_fail++; $display("FAIL rnd%0d_hold: got %h want %h", t, HEX, prev); end
                cyc++;
                @(negedge CLOCK_50);
            end
            n_cmp++; if (cyc != (dec ? int'(W) + 1 : 1)) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, cyc, dec ? W + 1 : 1);
            end
            n_cmp++; if (HEX !== exp) begin n_fail++; $display("FAIL rnd%0d_seg v=%0d dec=%0b: got %h want %h", t, v, dec, HEX, exp); end
            n_cmp++; if (overflow !== model_ovf(v, dec)) begin
                n_fail++; $display("FAIL rnd%0d_ovf: got %b want %b", t, overflow, model_ovf(v, dec));
            end
        end
    endtask

    initial begin
        value = '0; load = 1'b0; mode_dec = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_load_busy();
        test_blink();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
